// File: rtl/speed_switch_ctrl.sv
// Turbo/slow select for the CPU clock generator. Commits only on a bus-idle, CLK14M-aligned slot.
// Optional macro SPEED_DWELL_EN adds the minimum-dwell counter; without it arming is never held off.
module speed_switch_ctrl #(
  parameter int IDLE_CYCLES = 8,
  parameter int DWELL       = 255
) (
  input  logic CLK100M,
  input  logic RESET,
  input  logic CLK14M,
  input  logic REQ_TURBO,
  input  logic BUS_IDLE,
  output logic SPEED,
  output logic TURBO_ACK,
  output logic BUSY
);

  localparam logic [1:0] ST_SLOW     = 2'd0;
  localparam logic [1:0] ST_ARM_FAST = 2'd1;
  localparam logic [1:0] ST_FAST     = 2'd2;
  localparam logic [1:0] ST_ARM_SLOW = 2'd3;

  if (IDLE_CYCLES < 1 || IDLE_CYCLES > 255 || DWELL < 1 || DWELL > 65535) begin : g_bad_param
    $error("speed_switch_ctrl: IDLE_CYCLES or DWELL out of range");
  end

  logic [2:0] sync_reg;
  logic       edge14;
  logic [7:0] idle_cnt_reg;
  logic [7:0] idle_cnt_next;
  logic       idle_ok;
  logic       dwell_ok;
  logic [1:0] state_reg;
  logic [1:0] state_next;
  logic       speed_reg;
  logic       speed_next;
  logic       turbo_ack_reg;
  logic       busy_reg;
  logic       busy_next;

  // sync_reg[0..2] are q1..q3; CLK14M is touched nowhere else.
  assign edge14 = sync_reg[1] & ~sync_reg[2];

  assign idle_ok = (idle_cnt_reg == 8'(IDLE_CYCLES));

  always_comb begin
    idle_cnt_next = idle_cnt_reg;
    if (!BUS_IDLE)
      idle_cnt_next = 8'd0;
    else if (!idle_ok)
      idle_cnt_next = idle_cnt_reg + 8'd1;
  end

`ifdef SPEED_DWELL_EN
  logic [15:0] dwell_cnt_reg;
  logic [15:0] dwell_cnt_next;
  logic        commit;

  // Only a commit leaves an ARM state for the opposite stable state; aborts go back.
  assign commit = ((state_reg == ST_ARM_FAST) && (state_next == ST_FAST)) ||
                  ((state_reg == ST_ARM_SLOW) && (state_next == ST_SLOW));

  assign dwell_ok = (dwell_cnt_reg == 16'(DWELL));

  always_comb begin
    dwell_cnt_next = dwell_cnt_reg;
    if (commit)
      dwell_cnt_next = 16'd0;
    else if (!dwell_ok)
      dwell_cnt_next = dwell_cnt_reg + 16'd1;
  end

  always_ff @(posedge CLK100M or posedge RESET) begin
    if (RESET)
      dwell_cnt_reg <= 16'd0;
    else
      dwell_cnt_reg <= dwell_cnt_next;
  end
`else
  assign dwell_ok = 1'b1;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_SLOW:
        if (REQ_TURBO && dwell_ok) state_next = ST_ARM_FAST;
      ST_ARM_FAST:
        if (!REQ_TURBO)              state_next = ST_SLOW;
        else if (idle_ok && edge14)  state_next = ST_FAST;
      ST_FAST:
        if (!REQ_TURBO && dwell_ok) state_next = ST_ARM_SLOW;
      ST_ARM_SLOW:
        if (REQ_TURBO)               state_next = ST_FAST;
        else if (idle_ok && edge14)  state_next = ST_SLOW;
      default:
        state_next = ST_SLOW;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  assign speed_next = (state_next == ST_SLOW) || (state_next == ST_ARM_FAST);
  assign busy_next  = (state_next == ST_ARM_FAST) || (state_next == ST_ARM_SLOW);

  always_ff @(posedge CLK100M or posedge RESET) begin
    if (RESET) begin
      sync_reg      <= 3'b000;
      idle_cnt_reg  <= 8'd0;
      state_reg     <= ST_SLOW;
      speed_reg     <= 1'b1;
      turbo_ack_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      sync_reg      <= {sync_reg[1:0], CLK14M};
      idle_cnt_reg  <= idle_cnt_next;
      state_reg     <= state_next;
      speed_reg     <= speed_next;
      turbo_ack_reg <= ~speed_next;
      busy_reg      <= busy_next;
    end
  end

  assign SPEED     = speed_reg;
  assign TURBO_ACK = turbo_ack_reg;
  assign BUSY      = busy_reg;

endmodule
